t5_lsu: RTL

Load/store unit for the t5 core: the read-side counterpart of the ALU's store-data path. It accepts an effective address, a lane-replicated store word and fn3 from execute, and runs one data-bus cycle per accepted request. Load data is returned lane-extracted and sign/zero-extended. Misaligned accesses and bus faults are reported on `xstb`/`xerr` for the trap logic.

---
 rtl/t5_lsu_if.sv | 30 +++
 rtl/t5_lsu.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/t5_lsu_if.sv
// ============================================================================
// Module   : t5_lsu_if
// Brief    : Data-bus bundle between the t5 load/store unit and memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface t5_lsu_if;
  logic        dwb_cyc_o;
  logic        dwb_stb_o;
  logic        dwb_we_o;
  logic [31:2] dwb_adr_o;
  logic [3:0]  dwb_sel_o;
  logic [31:0] dwb_dat_o;
  logic [31:0] dwb_dat_i;
  logic        dwb_ack_i;
  logic        dwb_err_i;

  modport master (
    output dwb_cyc_o, dwb_stb_o, dwb_we_o, dwb_adr_o, dwb_sel_o, dwb_dat_o,
    input  dwb_dat_i, dwb_ack_i, dwb_err_i
  );

  modport slave (
    input  dwb_cyc_o, dwb_stb_o, dwb_we_o, dwb_adr_o, dwb_sel_o, dwb_dat_o,
    output dwb_dat_i, dwb_ack_i, dwb_err_i
  );
endinterface

`default_nettype wire

// File: rtl/t5_lsu.sv
// ============================================================================
// Module   : t5_lsu
// Brief    : t5 load/store unit; one data-bus cycle per request, load extension.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module t5_lsu #(
  parameter int TIMEOUT = 255
) (
  input  wire logic         sclk,
  input  wire logic         srst,
  input  wire logic         xreq,
  input  wire logic         xwe,
  input  wire logic [14:12] xfn3,
  input  wire logic [31:0]  xadr,
  input  wire logic [31:0]  xdat,
  t5_lsu_if.master          dwb,
  output logic              lstall,
  output logic [31:0]       mdat,
  output logic              mvld,
  output logic [1:0]        xstb,
  output logic              xwre,
  output logic              xerr
);

  localparam logic [7:0] c_timeout = 8'(TIMEOUT);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUS  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_cyc;
  logic        r_we;
  logic [31:2] r_adr;
  logic [1:0]  r_lane;
  logic [3:0]  r_sel;
  logic [31:0] r_dat;
  logic [2:0]  r_fn3;
  logic [7:0]  r_cnt;
  logic [31:0] r_mdat;
  logic        r_mvld;
  logic [1:0]  r_xstb;
  logic        r_xwre;
  logic        r_xerr;

  logic [1:0]  w_size;
  logic        w_misaligned;
  logic        w_accept;
  logic        w_trap;
  logic        w_timeout;
  logic        w_abort;
  logic [3:0]  w_sel;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  // Size 3 falls into the word case everywhere.
  assign w_size       = xfn3[13:12];
  assign w_misaligned = ((w_size == 2'b01) && xadr[0]) ||
                        (w_size[1] && (xadr[1:0] != 2'b00));
  assign w_accept     = (r_state == S_IDLE) && xreq && !w_misaligned;
  assign w_trap       = (r_state == S_IDLE) && xreq && w_misaligned;
  assign w_timeout    = (r_cnt == c_timeout);
  assign w_abort      = (r_state == S_BUS) && (dwb.dwb_err_i || w_timeout);

  always_comb begin
    w_sel = 4'b0000;
    case (w_size)
      2'b00:   w_sel = 4'b0001 << xadr[1:0];
      2'b01:   w_sel = xadr[1] ? 4'b1100 : 4'b0011;
      default: w_sel = 4'b1111;
    endcase
  end

  always_comb begin
    w_byte = dwb.dwb_dat_i[7:0];
    case (r_lane)
      2'b00:   w_byte = dwb.dwb_dat_i[7:0];
      2'b01:   w_byte = dwb.dwb_dat_i[15:8];
      2'b10:   w_byte = dwb.dwb_dat_i[23:16];
      default: w_byte = dwb.dwb_dat_i[31:24];
    endcase
    w_half = r_lane[1] ? dwb.dwb_dat_i[31:16] : dwb.dwb_dat_i[15:0];
    case (r_fn3[1:0])
      2'b00:   w_ext = {{24{w_byte[7] & ~r_fn3[2]}}, w_byte};
      2'b01:   w_ext = {{16{w_half[15] & ~r_fn3[2]}}, w_half};
      default: w_ext = dwb.dwb_dat_i;
    endcase
  end

  always_ff @(posedge sclk or negedge srst) begin
    if (!srst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // lstall covers the accept cycle so execute holds its operands until done.
  always_comb begin
    w_state_nxt = r_state;
    lstall      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_BUS;
          lstall      = 1'b1;
        end
      end
      S_BUS: begin
        if (w_abort || dwb.dwb_ack_i) begin
          w_state_nxt = S_IDLE;
        end else begin
          lstall      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge srst) begin
    if (!srst) begin
      r_cyc  <= 1'b0;
      r_we   <= 1'b0;
      r_adr  <= '0;
      r_lane <= 2'b00;
      r_sel  <= 4'b0000;
      r_dat  <= '0;
      r_fn3  <= 3'b000;
      r_cnt  <= 8'd0;
      r_mdat <= '0;
      r_mvld <= 1'b0;
      r_xstb <= 2'b00;
      r_xwre <= 1'b0;
      r_xerr <= 1'b0;
    end else begin
      r_mvld <= 1'b0;
      r_xerr <= 1'b0;
      r_xstb <= 2'b00;
      if (w_accept) begin
        r_cyc  <= 1'b1;
        r_we   <= xwe;
        r_adr  <= xadr[31:2];
        r_lane <= xadr[1:0];
        r_sel  <= w_sel;
        r_dat  <= xdat;
        r_fn3  <= xfn3;
        r_cnt  <= 8'd0;
      end
      if (w_trap) begin
        r_xstb <= 2'b11;
        r_xwre <= xwe;
      end
      if (r_state == S_BUS) begin
        if (r_cnt != 8'hFF) begin
          r_cnt <= r_cnt + 8'd1;
        end
        // Error or timeout takes precedence over a coincident ack.
        if (w_abort) begin
          r_cyc  <= 1'b0;
          r_xerr <= 1'b1;
          r_xwre <= r_we;
        end else if (dwb.dwb_ack_i) begin
          r_cyc  <= 1'b0;
          r_xstb <= 2'b10;
          if (!r_we) begin
            r_mdat <= w_ext;
            r_mvld <= 1'b1;
          end
        end
      end
    end
  end

  assign dwb.dwb_cyc_o = r_cyc;
  assign dwb.dwb_stb_o = r_cyc;
  assign dwb.dwb_we_o  = r_we;
  assign dwb.dwb_adr_o = r_adr;
  assign dwb.dwb_sel_o = r_sel;
  assign dwb.dwb_dat_o = r_dat;

  assign mdat = r_mdat;
  assign mvld = r_mvld;
  assign xstb = r_xstb;
  assign xwre = r_xwre;
  assign xerr = r_xerr;

endmodule

`default_nettype wire
